// File: rtl/fir_pkg.sv
// Shared constants and sample type for the FIR filter datapath and its feeders.
package fir_pkg;
  localparam int unsigned SAMPLE_WIDTH = 8;
  localparam int unsigned FIR_TAPS     = 30;
  localparam int unsigned MIN_SPACING  = FIR_TAPS + 3;

  typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;
endpackage

// File: rtl/sample_pacer_if.sv
// Upstream handshake plus paced sample strobe for the sample pacer.
interface sample_pacer_if
  import fir_pkg::*;
#(
  parameter int unsigned WIDTH = SAMPLE_WIDTH
);
  logic                    in_valid;
  logic signed [WIDTH-1:0] in_data;
  logic                    in_ready;
  logic                    sample_valid;
  logic signed [WIDTH-1:0] sample_data;

  modport master (output in_valid, in_data, input in_ready, sample_valid, sample_data);
  modport slave  (input in_valid, in_data, output in_ready, sample_valid, sample_data);
endinterface

// File: rtl/sample_pacer_sync_fifo.sv
// Single-clock FIFO with registered read data; full/empty derived from the level count.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             do_push, do_pop;

  always_comb begin
    full     = (level_q == (AW+1)'(DEPTH));
    empty    = (level_q == '0);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    rdata_d  = rdata_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      rdata_d  = mem_q[rd_ptr_q];
    end
    if (do_push && !do_pop)      level_d = level_q + 1'b1;
    else if (do_pop && !do_push) level_d = level_q - 1'b1;
    level = level_q;
    rdata = rdata_q;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      rdata_q  <= rdata_d;
    end
  end
endmodule

// File: rtl/sample_pacer.sv
// Buffers bursty upstream samples and releases one per CLKS_PER_SAMPLE clocks,
// zero-filling (and counting) when the buffer runs dry at a tick.
module sample_pacer
  import fir_pkg::*;
#(
  parameter int unsigned WIDTH           = SAMPLE_WIDTH,
  parameter int unsigned DEPTH           = 16,
  parameter int unsigned CLKS_PER_SAMPLE = 40
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  sample_pacer_if.slave          bus,
  output logic [$clog2(DEPTH):0] fill_level,
  output logic                   underrun,
  output logic [15:0]            underrun_count
);
  localparam int unsigned CW = $clog2(CLKS_PER_SAMPLE);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_SAMPLE - 1);

  if (CLKS_PER_SAMPLE < MIN_SPACING) begin : g_bad_spacing
    $error("sample_pacer: CLKS_PER_SAMPLE below filter idle-to-idle spacing");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sample_pacer: DEPTH must be a power of two and at least 2");
  end

  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             underrun_q, underrun_d;
  logic             zero_sel_q, zero_sel_d;
  logic [15:0]      count_q, count_d;
  logic             tick, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [WIDTH-1:0] fifo_rdata;
  logic [$clog2(DEPTH):0] fifo_level;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (bus.in_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // sample_data muxes the FIFO's held read register against zero, so the
  // last emitted value (popped or zero-filled) persists between strobes.
  always_comb begin
    tick       = enable && (cnt_q == LAST_CNT);
    cnt_d      = (!enable || tick) ? '0 : cnt_q + 1'b1;
    fifo_pop   = tick && !fifo_empty;
    fifo_push  = bus.in_valid && !fifo_full && !rst;
    valid_d    = tick;
    underrun_d = tick && fifo_empty;
    zero_sel_d = tick ? fifo_empty : zero_sel_q;
    count_d    = count_q;
    if (underrun_d && count_q != '1) count_d = count_q + 1'b1;

    bus.in_ready     = !fifo_full && !rst;
    bus.sample_valid = valid_q;
    bus.sample_data  = zero_sel_q ? '0 : fifo_rdata;
    fill_level       = fifo_level;
    underrun         = underrun_q;
    underrun_count   = count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      underrun_q <= 1'b0;
      zero_sel_q <= 1'b0;
      count_q    <= '0;
    end else begin
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      underrun_q <= underrun_d;
      zero_sel_q <= zero_sel_d;
      count_q    <= count_d;
    end
  end
endmodule

// File: tb/tb_sample_pacer.sv
// Bench for sample_pacer: queue-based reference model checked every cycle, plus directed literal checks.
module tb_sample_pacer;
  import fir_pkg::*;

  localparam int unsigned D   = 16;
  localparam int unsigned CPS = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [4:0]  fill_level;
  logic        underrun;
  logic [15:0] underrun_count;

  sample_pacer_if #(.WIDTH(8)) bus ();

  sample_pacer #(
    .WIDTH           (8),
    .DEPTH           (D),
    .CLKS_PER_SAMPLE (CPS)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .bus            (bus.slave),
    .fill_level     (fill_level),
    .underrun       (underrun),
    .underrun_count (underrun_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of buffered samples and a count of consecutive enabled cycles.
  logic [7:0]  m_q[$];
  int          m_run = 0;
  logic        m_valid = 1'b0;
  logic        m_under = 1'b0;
  logic [7:0]  m_data = '0;
  logic [15:0] m_count = '0;
  bit          live = 1'b0;
  logic [7:0]  strobes[$];

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_run   = 0;
      m_valid = 1'b0;
      m_under = 1'b0;
      m_data  = '0;
      m_count = '0;
      live    = 1'b1;
    end else begin
      bit tk;
      bit rdy;
      tk      = enable && (((m_run + 1) % CPS) == 0);
      rdy     = m_q.size() < D;
      m_valid = tk;
      m_under = 1'b0;
      if (tk) begin
        if (m_q.size() > 0) m_data = m_q.pop_front();
        else begin
          m_data  = '0;
          m_under = 1'b1;
          if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
        end
      end
      if (bus.in_valid && rdy) m_q.push_back(bus.in_data);
      m_run = enable ? m_run + 1 : 0;
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk("sample_valid", {31'd0, bus.sample_valid}, {31'd0, m_valid});
      chk("sample_data", {24'd0, bus.sample_data}, {24'd0, m_data});
      chk("underrun", {31'd0, underrun}, {31'd0, m_under});
      chk("underrun_count", {16'd0, underrun_count}, {16'd0, m_count});
      chk("fill_level", {27'd0, fill_level}, m_q.size());
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, (!rst && m_q.size() < D)});
      if (bus.sample_valid) strobes.push_back(bus.sample_data);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [7:0] burst [4];

  initial begin
    burst = '{8'd5, 8'hFD, 8'd127, 8'h80};
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    step(3);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    rst = 1'b0;
    chk("rst_fill", {27'd0, fill_level}, 32'd0);
    chk("rst_valid", {31'd0, bus.sample_valid}, 32'd0);
    chk("rst_count", {16'd0, underrun_count}, 32'd0);

    // Idle pacing: zero-filled strobes 40 clocks apart.
    enable = 1'b1;
    step(39);
    chk("first_tick_early", {31'd0, bus.sample_valid}, 32'd0);
    step(1);
    chk("first_strobe_valid", {31'd0, bus.sample_valid}, 32'd1);
    chk("first_strobe_under", {31'd0, underrun}, 32'd1);
    chk("first_strobe_data", {24'd0, bus.sample_data}, 32'd0);
    step(80);
    chk("three_underruns", {16'd0, underrun_count}, 32'd3);

    // Burst of four, released one per tick in order.
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = burst[i];
      step(1);
    end
    bus.in_valid = 1'b0;
    chk("burst_fill", {27'd0, fill_level}, 32'd4);
    strobes.delete();
    step(160);
    chk("burst_strobes", strobes.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < strobes.size()) chk("burst_data", {24'd0, strobes[i]}, {24'd0, burst[i]});
    end

    // Fill to capacity with pacing stopped; the 17th is refused.
    enable = 1'b0;
    step(1);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.in_data = 8'($urandom);
      step(1);
    end
    chk("full_level", {27'd0, fill_level}, 32'd16);
    chk("full_ready", {31'd0, bus.in_ready}, 32'd0);
    bus.in_data = 8'h55;
    step(1);
    chk("full_17th", {27'd0, fill_level}, 32'd16);
    bus.in_valid = 1'b0;
    enable = 1'b1;
    step(16 * 40 + 5);
    chk("drained", {27'd0, fill_level}, 32'd0);

    // Push into an empty FIFO on the tick cycle itself.
    enable = 1'b0;
    step(1);
    enable = 1'b1;
    step(39);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd9;
    step(1);
    bus.in_valid = 1'b0;
    chk("coinc_valid", {31'd0, bus.sample_valid}, 32'd1);
    chk("coinc_data", {24'd0, bus.sample_data}, 32'd0);
    chk("coinc_under", {31'd0, underrun}, 32'd1);
    chk("coinc_fill", {27'd0, fill_level}, 32'd1);
    step(40);
    chk("coinc_next_data", {24'd0, bus.sample_data}, 32'd9);

    // Reset mid-stream with six buffered samples.
    enable = 1'b0;
    step(1);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.in_data = 8'($urandom);
      step(1);
    end
    bus.in_valid = 1'b0;
    chk("pre_rst_fill", {27'd0, fill_level}, 32'd6);
    enable = 1'b1;
    step(20);
    rst = 1'b1;
    step(1);
    chk("mid_rst_fill", {27'd0, fill_level}, 32'd0);
    chk("mid_rst_count", {16'd0, underrun_count}, 32'd0);
    chk("mid_rst_ready", {31'd0, bus.in_ready}, 32'd0);
    rst = 1'b0;
    step(39);
    chk("post_rst_quiet", {31'd0, bus.sample_valid}, 32'd0);
    step(1);
    chk("post_rst_strobe", {31'd0, bus.sample_valid}, 32'd1);

    // Counter saturation.
    force dut.count_q = 16'hFFFE;
    m_count = 16'hFFFE;
    #1;
    release dut.count_q;
    step(40);
    chk("sat_first", {16'd0, underrun_count}, 32'h0000FFFF);
    step(80);
    chk("sat_hold", {16'd0, underrun_count}, 32'h0000FFFF);

    // Random traffic with occasional enable toggles.
    for (int i = 0; i < 800; i++) begin
      bus.in_valid = ($urandom_range(0, 3) == 0);
      bus.in_data  = 8'($urandom);
      if ($urandom_range(0, 99) == 0) enable = ~enable;
      step(1);
    end
    bus.in_valid = 1'b0;
    step(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sample_pacer.md
Name: sample_pacer

Overview:
- Upstream stage of the 8-bit FIR filter.
- Accepts bursty signed 8-bit samples over a valid/ready handshake and buffers them in a small FIFO.
- Releases one sample per CLKS_PER_SAMPLE clocks as a single-cycle strobe plus data, so the filter receives a fixed-rate stream and is never re-strobed while it is still accumulating.
- On underrun it inserts a zero sample so the filter's sample timing is preserved, and counts the event.

Parameters:
- WIDTH, 8, sample width (signed, two's complement).
- DEPTH, 16, FIFO depth in samples; power of two, at least 2.
- CLKS_PER_SAMPLE, 40, clocks between output strobes; elaboration error if less than MIN_SPACING from the package.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  1 = pacing runs; 0 = tick counter held, no strobes.
- in_valid  in  1  upstream sample present.
- in_data  in  WIDTH  signed upstream sample.
- in_ready  out  1  FIFO can accept; equals not full and not rst.
- sample_valid  out  1  single-cycle strobe; connects to the filter's single_valid_in.
- sample_data  out  WIDTH  signed sample, valid when sample_valid = 1; holds its value otherwise.
- fill_level  out  clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- underrun  out  1  single-cycle pulse, coincident with a zero-filled strobe.
- underrun_count  out  16  number of zero-filled strobes; saturates at 16'hFFFF.

Behaviour:
- Reset values: tick counter 0, FIFO empty, fill_level 0, sample_valid 0, sample_data 0, underrun 0, underrun_count 0. in_ready is 0 while rst = 1.
- Reset mid-operation discards all FIFO contents and any pending tick.
- Tick counter:
  - With enable = 1, counts 0..CLKS_PER_SAMPLE-1 and wraps to 0.
  - A tick occurs in the cycle where the count equals CLKS_PER_SAMPLE-1.
  - With enable = 0, the counter is forced to 0 and no tick occurs.
  - After enable rises, the first tick comes CLKS_PER_SAMPLE cycles later.
- Push: in any cycle with in_valid and in_ready both 1, in_data is written at the write pointer.
- Pop on tick:
  - If the FIFO is non-empty in the tick cycle, the head is popped and registered.
  - In the next cycle: sample_valid = 1 and sample_data = popped value.
  - Latency from tick to strobe is 1 clock.
- Underrun on tick:
  - If the FIFO is empty in the tick cycle, the next cycle has sample_valid = 1, sample_data = 0 and underrun = 1.
  - underrun_count increments by 1 unless already at 16'hFFFF.
- Strobe spacing:
  - sample_valid is high exactly 1 cycle.
  - Consecutive strobes are exactly CLKS_PER_SAMPLE cycles apart while enable = 1.
- Simultaneous events:
  - Push and pop in the same cycle with the FIFO partially full: both occur, fill_level unchanged.
  - Push while empty coincident with a tick: the pop sees empty, so a zero is emitted and the pushed sample stays for the next tick.
  - While full, in_ready = 0, even in a pop cycle; no pass-through.
- Pointers: write and read pointers are clog2(DEPTH) bits and wrap naturally. Full/empty come from fill_level.
- Arithmetic: no arithmetic on sample data; values pass bit-exact.

Decomposition:
- Shared package fir_pkg:
  - SAMPLE_WIDTH = 8.
  - FIR_TAPS = 30.
  - MIN_SPACING = FIR_TAPS + 3, the filter's idle-to-idle cycle count.
  - typedef sample_t (logic signed [SAMPLE_WIDTH-1:0]).
- One sub-module, sync_fifo:
  - Parameterised WIDTH and DEPTH.
  - Ports: push, pop, wdata, rdata, full, empty, level.
  - Registered read data.
  - Instantiated once.
- Tick counter and underrun logic live in sample_pacer.

Test Plan:
- Reset then enable = 1, no input -> strobe with sample_data 0 and underrun pulse at cycles 41, 81, 121 after enable; underrun_count = 3.
- Burst push 5, -3, 127, -128 back-to-back -> fill_level 4; next four strobes carry 5, -3, 127, -128 exactly 40 cycles apart; then zero-fill.
- Push 17 samples with no ticks (enable = 0) -> first 16 accepted, in_ready low after the 16th, fill_level 16; the 17th is not accepted.
- Push coincident with a tick on an empty FIFO (value 9) -> that strobe is 0 with underrun; the next strobe carries 9.
- Assert rst mid-stream with fill_level 6 -> next cycle fill_level 0, underrun_count 0, no strobe until a fresh CLKS_PER_SAMPLE period after rst drops.
- Force underrun_count to 16'hFFFE via 2 extra underruns -> count holds at 16'hFFFF.
- Connect the FIR and feed an impulse of 64 -> filter outputs follow the coefficient sequence scaled by 64/256, one output per strobe.
